// File: rtl/axis_fifo_pkg.sv
// rtl/axis_fifo_pkg.sv - shared FSM encodings and pointer arithmetic for the stream FIFOs
package axis_fifo_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DROP = 1'b1
  } state_e;

  // Widest pointer any FIFO in the family uses; callers zero-extend and truncate.
  localparam int PTR_MAX = 16;

  // Modular distance a - b; the low bits of the result are valid for any narrower pointer.
  function automatic logic [PTR_MAX-1:0] ptr_diff(input logic [PTR_MAX-1:0] a,
                                                  input logic [PTR_MAX-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/lutram_sdp.sv
// rtl/lutram_sdp.sv - simple dual-port LUT RAM, synchronous write, asynchronous read
module lutram_sdp #(
  parameter int WIDTH = 8,
  parameter int ABITS = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ABITS-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  // No reset: contents are only meaningful behind the owner's pointers.
  logic [WIDTH-1:0] mem_q [2**ABITS];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_pfifo.sv
// rtl/axis_pfifo.sv - packet-mode stream FIFO: reader sees only frames committed by tlast
module axis_pfifo #(
  parameter int WIDTH = 8,
  parameter int ABITS = 4,
  parameter int DROP  = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic [ABITS:0]   level_o,
  output logic             drop_o
);
  import axis_fifo_pkg::*;

  localparam int PW = ABITS + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(2**ABITS);

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   wr_cmt_q, wr_cmt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            rdy_q, rdy_d;

  logic [PW-1:0]   used;
  logic            full;
  logic            wr_acc;
  logic            rd_acc;
  logic            ram_we;
  logic [WIDTH:0]  rd_word;

  always_comb begin
    used     = PW'(ptr_diff(PTR_MAX'(wr_ptr_q), PTR_MAX'(rd_ptr_q)));
    full     = (used == DEPTH_P);
    m_tvalid = (rd_ptr_q != wr_cmt_q);
    level_o  = PW'(ptr_diff(PTR_MAX'(wr_cmt_q), PTR_MAX'(rd_ptr_q)));
    // rdy_q keeps the upstream port closed while in reset and for the release cycle.
    s_tready = rdy_q & ((state_q == ST_DROP) | ~full);
    wr_acc   = s_tvalid & s_tready;
    rd_acc   = m_tvalid & m_tready;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    rd_ptr_d = rd_ptr_q;
    rdy_d    = 1'b1;
    ram_we   = 1'b0;
    drop_o   = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (wr_acc) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (s_tlast) wr_cmt_d = wr_ptr_q + 1'b1;
        end else if (DROP != 0 && full && (wr_cmt_q == rd_ptr_q)) begin
          // The whole buffer is one unfinished frame: it can never fit, so rewind and discard.
          state_d  = ST_DROP;
          wr_ptr_d = wr_cmt_q;
        end
      end
      ST_DROP: begin
        if (wr_acc && s_tlast) begin
          drop_o  = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_FILL;
      wr_ptr_q <= '0;
      wr_cmt_q <= '0;
      rd_ptr_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_cmt_q <= wr_cmt_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= rdy_d;
    end
  end

  lutram_sdp #(
    .WIDTH (WIDTH + 1),
    .ABITS (ABITS)
  ) u_ram (
    .clk   (aclk),
    .we    (ram_we),
    .waddr (wr_ptr_q[ABITS-1:0]),
    .wdata ({s_tlast, s_tdata}),
    .raddr (rd_ptr_q[ABITS-1:0]),
    .rdata (rd_word)
  );

  assign {m_tlast, m_tdata} = rd_word;

endmodule
